// File: rtl/priority_encoder_8to3.sv
// Registered MSB-first priority encoder: y = index of highest set bit of i, valid when enabled and i != 0.
// Latency: 1 cycle. No backpressure; a new vector is accepted every cycle.
module priority_encoder_8to3 #(
    parameter  int WIDTH = 8,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] i,
    output logic [OUT_W-1:0] y,
    output logic             valid
);

    logic [OUT_W-1:0] enc_idx;
    logic             enc_hit;

    // Descending scan: the first set bit found from the top wins, lower bits are masked by enc_hit.
    always_comb begin
        enc_idx = '0;
        enc_hit = 1'b0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (!enc_hit && i[k]) begin
                enc_idx = OUT_W'(k);
                enc_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= '0;
            valid <= 1'b0;
        end else if (enable && enc_hit) begin
            y     <= enc_idx;
            valid <= 1'b1;
        end else begin
            y     <= '0;
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Directed bench for priority_encoder_8to3 at WIDTH=8 and WIDTH=16 sharing clock, reset and enable.
module tb_priority_encoder_8to3;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  i8;
    logic [15:0] i16;
    logic [2:0]  y8;
    logic [3:0]  y16;
    logic        valid8;
    logic        valid16;

    int checks;
    int errors;

    priority_encoder_8to3 #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .i      (i8),
        .y      (y8),
        .valid  (valid8)
    );

    priority_encoder_8to3 #(.WIDTH(16)) dut16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .i      (i16),
        .y      (y16),
        .valid  (valid16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive a vector, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic en, input logic [7:0] v8, input logic [15:0] v16);
        enable = en;
        i8     = v8;
        i16    = v16;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int ey8, input int ev8, input int ey16, input int ev16);
        check({tag, " y8"},     32'(y8),      32'(ey8));
        check({tag, " valid8"}, 32'(valid8),  32'(ev8));
        check({tag, " y16"},    32'(y16),     32'(ey16));
        check({tag, " valid16"},32'(valid16), 32'(ev16));
    endtask

    typedef struct {
        logic [7:0]  v8;
        int          e8;
        logic [15:0] v16;
        int          e16;
    } vec_t;

    vec_t prio_tab[5];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        i8     = '0;
        i16    = '0;

        prio_tab[0] = '{8'hFF, 7, 16'hFFFF, 15};
        prio_tab[1] = '{8'h81, 7, 16'h8001, 15};
        prio_tab[2] = '{8'h03, 1, 16'h0003, 1};
        prio_tab[3] = '{8'h78, 6, 16'h0078, 6};
        prio_tab[4] = '{8'h01, 0, 16'h0100, 8};

        #2;
        expect_out("reset_init", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        expect_out("reset_held", 0, 0, 0, 0);
        #2 rst_n = 1'b1;

        // Multi-bit request
        apply(1'b1, 8'b0111_1000, 16'h0078);
        expect_out("multibit", 6, 1, 6, 1);

        // Async reset mid-cycle clears outputs before the next edge and holds while low
        #2 rst_n = 1'b0;
        #1;
        expect_out("rst_async", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        expect_out("rst_hold", 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        apply(1'b1, 8'b0111_1000, 16'h0078);
        expect_out("rst_release", 6, 1, 6, 1);

        // One-hot sweep on consecutive cycles; just before each edge the previous result must persist
        for (int k = 6; k >= 0; k--) begin
            enable = 1'b1;
            i8     = 8'd1 << k;
            i16    = 16'd1 << (k + 9);
            #3;
            check("lag y8", 32'(y8), (k == 6) ? 32'd6 : 32'(k + 1));
            @(posedge clk);
            #1;
            check("sweep y8",     32'(y8),      32'(k));
            check("sweep valid8", 32'(valid8),  32'd1);
            check("sweep y16",    32'(y16),     32'(k + 9));
            check("sweep valid16",32'(valid16), 32'd1);
        end

        foreach (prio_tab[n]) begin
            apply(1'b1, prio_tab[n].v8, prio_tab[n].v16);
            expect_out("priority", prio_tab[n].e8, 1, prio_tab[n].e16, 1);
        end

        apply(1'b1, 8'h00, 16'h0000);
        expect_out("idle_zero", 0, 0, 0, 0);
        apply(1'b1, 8'h80, 16'h8000);
        expect_out("top_bit", 7, 1, 15, 1);
        apply(1'b0, 8'hFF, 16'hFFFF);
        expect_out("disabled", 0, 0, 0, 0);
        apply(1'b1, 8'h40, 16'h4000);
        expect_out("reenable", 6, 1, 14, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
